fmc_adc_ext_trig_cond: RTL and testbench

//  Conditions the asynchronous external trigger input of one FMC-ADC mezzanine before it enters the

---
 rtl/fmc_adc_trig_pkg.sv | 19 +
 rtl/fmc_adc_glitch_filt.sv | 53 +++++
 rtl/fmc_adc_ext_trig_cond.sv | 97 +++++++++
 tb/tb_fmc_adc_ext_trig_cond.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fmc_adc_trig_pkg.sv
// Shared types and constants for the FMC-ADC trigger path.
// Used by the external trigger conditioner and the channel threshold triggers.
package fmc_adc_trig_pkg;

   typedef enum logic [1:0] {IDLE, DELAY, FIRE} t_ext_trig_state;

   localparam int unsigned C_SYNC_STAGES_DEF = 2;
   localparam int unsigned C_GLITCH_LEN_DEF  = 4;
   localparam int unsigned C_DLY_WIDTH_DEF   = 32;

   // Input-change to trig_p_o latency with zero programmed delay.
   function automatic int unsigned f_base_lat(input int unsigned sync_stages,
                                               input int unsigned glitch_len);
      return sync_stages + glitch_len + 1;
   endfunction

   localparam int unsigned C_BASE_LAT = f_base_lat(C_SYNC_STAGES_DEF, C_GLITCH_LEN_DEF);

endpackage

// File: rtl/fmc_adc_glitch_filt.sv
// Synchroniser plus stability counter: the filtered level only follows the synced
// input after it has differed for g_GLITCH_LEN consecutive cycles.
module fmc_adc_glitch_filt
   import fmc_adc_trig_pkg::*;
#(
   parameter int unsigned g_SYNC_STAGES = C_SYNC_STAGES_DEF,
   parameter int unsigned g_GLITCH_LEN  = C_GLITCH_LEN_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic filt_o
);

   localparam int unsigned C_CNT_W = $clog2(g_GLITCH_LEN + 1);
   localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(g_GLITCH_LEN - 1);

   logic [g_SYNC_STAGES-1:0] sync_d, sync_q;
   logic [C_CNT_W-1:0]       cnt_d, cnt_q;
   logic                     filt_d, filt_q;
   logic                     synced;

   assign synced = sync_q[g_SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[g_SYNC_STAGES-2:0], async_i};
      cnt_d  = '0;
      filt_d = filt_q;
      // Any sample equal to the filtered level restarts the count.
      if (synced != filt_q) begin
         if (cnt_q == C_CNT_MAX) begin
            filt_d = synced;
         end else begin
            cnt_d = cnt_q + C_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/fmc_adc_ext_trig_cond.sv
// External trigger conditioner: filtered edge detect, programmable delay and a
// non-retriggerable 1-cycle output pulse with sticky overrun flag.
module fmc_adc_ext_trig_cond
   import fmc_adc_trig_pkg::*;
#(
   parameter int unsigned g_SYNC_STAGES = C_SYNC_STAGES_DEF,
   parameter int unsigned g_GLITCH_LEN  = C_GLITCH_LEN_DEF,
   parameter int unsigned g_DLY_WIDTH   = C_DLY_WIDTH_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   ext_trig_a_i,
   input  logic                   en_i,
   input  logic                   pol_i,
   input  logic [g_DLY_WIDTH-1:0] dly_i,
   input  logic                   ovr_clr_i,
   output logic                   trig_p_o,
   output logic                   busy_o,
   output logic                   ovr_o
);

   logic                   filt;
   logic                   filt_dly_d, filt_dly_q;
   logic                   edge_p_d, edge_p_q;
   t_ext_trig_state        state_d, state_q;
   logic [g_DLY_WIDTH-1:0] cnt_d, cnt_q;
   logic                   ovr_d, ovr_q;

   fmc_adc_glitch_filt #(
      .g_SYNC_STAGES (g_SYNC_STAGES),
      .g_GLITCH_LEN  (g_GLITCH_LEN)
   ) u_filt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (ext_trig_a_i),
      .filt_o  (filt)
   );

   always_comb begin
      filt_dly_d = filt;
      edge_p_d   = pol_i ? (filt_dly_q & ~filt) : (~filt_dly_q & filt);
      state_d    = state_q;
      cnt_d      = cnt_q;
      ovr_d      = ovr_q & ~ovr_clr_i;
      if (!en_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (edge_p_q) begin
                  if (dly_i == '0) begin
                     state_d = FIRE;
                  end else begin
                     cnt_d   = dly_i - g_DLY_WIDTH'(1);
                     state_d = DELAY;
                  end
               end
            end
            DELAY: begin
               // Set is applied after the clear so a coincident clear loses.
               if (edge_p_q) ovr_d = 1'b1;
               if (cnt_q == '0) begin
                  state_d = FIRE;
               end else begin
                  cnt_d = cnt_q - g_DLY_WIDTH'(1);
               end
            end
            FIRE: begin
               if (edge_p_q) ovr_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         filt_dly_q <= 1'b0;
         edge_p_q   <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         ovr_q      <= 1'b0;
      end else begin
         filt_dly_q <= filt_dly_d;
         edge_p_q   <= edge_p_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovr_q      <= ovr_d;
      end
   end

   assign trig_p_o = (state_q == FIRE);
   assign busy_o   = (state_q == DELAY);
   assign ovr_o    = ovr_q;

endmodule

// File: tb/tb_fmc_adc_ext_trig_cond.sv
// Directed scenarios plus randomized input against an event-level reference model.
module tb_fmc_adc_ext_trig_cond;

   localparam int S  = 2;
   localparam int G  = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst, ext, en, pol, ovr_clr;
   logic [DW-1:0] dly;
   logic          trig, busy, ovr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int pulses[$];

   fmc_adc_ext_trig_cond #(
      .g_SYNC_STAGES (S),
      .g_GLITCH_LEN  (G),
      .g_DLY_WIDTH   (DW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .ext_trig_a_i (ext),
      .en_i         (en),
      .pol_i        (pol),
      .dly_i        (dly),
      .ovr_clr_i    (ovr_clr),
      .trig_p_o     (trig),
      .busy_o       (busy),
      .ovr_o        (ovr)
   );

   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse times are recorded as the number of rising edges seen so far.
   always @(negedge clk) begin
      if (trig === 1'b1) pulses.push_back(cyc);
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
   end

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Latency from the first sampling edge after the input change at c0.
   function automatic int lat_of(input int p0, input int c0);
      return (pulses.size() > p0) ? pulses[p0] - c0 - 1 : -1;
   endfunction

   initial begin
      int p0, c0, c1, b0;
      int lvl, start_k, fire_k, ovr_k, run, idx;
      bit cur, all_diff, v;
      bit xs[$];

      rst = 1'b1; ext = 1'b0; en = 1'b1; pol = 1'b0; dly = '0; ovr_clr = 1'b0;
      adv(3);
      chk("rst_trig", trig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", ovr, 0);
      rst = 1'b0;
      adv(5);

      // 1: plain rising edge, no delay
      p0 = pulses.size(); b0 = busy_cnt; c0 = cyc; ext = 1'b1;
      adv(20);
      chk("t1_count", pulses.size() - p0, 1);
      chk("t1_lat", lat_of(p0, c0), 7);
      chk("t1_busy", busy_cnt - b0, 0);
      ext = 1'b0;
      adv(15);

      // 2: short glitches rejected, then a real edge with dly=3
      dly = 3; p0 = pulses.size(); b0 = busy_cnt;
      repeat (2) begin
         ext = 1'b1; #10; ext = 1'b0; #10;
      end
      adv(1);
      c0 = cyc; ext = 1'b1;
      adv(25);
      chk("t2_count", pulses.size() - p0, 1);
      chk("t2_lat", lat_of(p0, c0), 10);
      chk("t2_busy", busy_cnt - b0, 3);
      ext = 1'b0;
      adv(15);
      chk("t2_fall", pulses.size() - p0, 1);

      // 3: falling-edge polarity
      pol = 1'b1; dly = 0;
      adv(3);
      p0 = pulses.size(); ext = 1'b1;
      adv(25);
      chk("t3_rise", pulses.size() - p0, 0);
      c1 = cyc; ext = 1'b0;
      adv(15);
      chk("t3_count", pulses.size() - p0, 1);
      chk("t3_lat", lat_of(p0, c1), 7);
      pol = 1'b0;
      adv(5);
      chk("t3_polchg", pulses.size() - p0, 1);

      // 4: second edge during a long delay is dropped and flagged
      dly = 50; p0 = pulses.size(); c0 = cyc; ext = 1'b1;
      adv(8);
      ext = 1'b0;
      adv(12);
      chk("t4_ovr_pre", ovr, 0);
      ext = 1'b1;
      adv(15);
      chk("t4_ovr_set", ovr, 1);
      chk("t4_busy", busy, 1);
      adv(45);
      chk("t4_count", pulses.size() - p0, 1);
      chk("t4_lat", lat_of(p0, c0), 57);
      ovr_clr = 1'b1;
      adv(1);
      ovr_clr = 1'b0;
      chk("t4_ovr_clr", ovr, 0);
      ext = 1'b0;
      adv(10);

      // 5: disable aborts a pending trigger; re-enable with input high is silent
      p0 = pulses.size(); c0 = cyc; ext = 1'b1;
      adv(28);
      chk("t5_busy", busy, 1);
      en = 1'b0;
      adv(1);
      chk("t5_busy_off", busy, 0);
      adv(60);
      chk("t5_nopulse", pulses.size() - p0, 0);
      en = 1'b1;
      adv(70);
      chk("t5_reen", pulses.size() - p0, 0);
      ext = 1'b0;
      adv(10);

      // 6: reset mid-delay discards the trigger
      p0 = pulses.size(); ext = 1'b1;
      adv(20);
      chk("t6_busy", busy, 1);
      rst = 1'b1; ext = 1'b0;
      adv(1);
      rst = 1'b0;
      chk("t6_trig", trig, 0);
      chk("t6_busy0", busy, 0);
      chk("t6_ovr", ovr, 0);
      adv(80);
      chk("t6_nopulse", pulses.size() - p0, 0);
      dly = 0; p0 = pulses.size(); c0 = cyc; ext = 1'b1;
      adv(15);
      chk("t6_count", pulses.size() - p0, 1);
      chk("t6_lat", lat_of(p0, c0), 7);
      ext = 1'b0;
      adv(10);

      // Random runs against the reference model
      for (int t = 0; t < 4; t++) begin
         pol = 1'($urandom_range(0, 1));
         dly = DW'($urandom_range(0, 6));
         rst = 1'b1; ext = 1'b0;
         adv(2);
         rst = 1'b0;
         xs.delete();
         lvl = 0; start_k = -100; fire_k = -100; ovr_k = -1; run = 0; cur = 1'b0;
         for (int k = 0; k < 300; k++) begin
            if (k >= 8 && run == 0) begin
               cur = 1'($urandom_range(0, 1));
               run = $urandom_range(1, 10);
            end
            if (run > 0) run--;
            ext = cur;
            adv(1);
            xs.push_back(cur);
            chk("rnd_trig", trig, (k == fire_k));
            chk("rnd_busy", busy, (k >= start_k && k < fire_k));
            chk("rnd_ovr", ovr, (ovr_k >= 0 && k >= ovr_k));
            // Level flips once the G most recent synced samples all differ from it.
            all_diff = 1'b1;
            for (int j = 0; j < G; j++) begin
               idx = k - S - j;
               v = (idx < 0) ? 1'b0 : xs[idx];
               if (int'(v) == lvl) all_diff = 1'b0;
            end
            if (all_diff) begin
               lvl = 1 - lvl;
               if (lvl != int'(pol)) begin
                  if (k + 1 <= fire_k) begin
                     if (ovr_k < 0) ovr_k = k + 2;
                  end else begin
                     start_k = k + 2;
                     fire_k  = k + 2 + int'(dly);
                  end
               end
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
